// File: rtl/routex_sink_multi.sv
// routex_sink_multi: multi-lane frame parser at the sink end of the routex fabric.
// Classifies every lane of a beat (route/header/length/payload), extracts DEST and counts frames.
module routex_sink_multi #(
    parameter int N       = 8,
    parameter int W       = 64,
    parameter int DEST_W  = 16,
    parameter int LEN_W   = 16,
    parameter int MAX_LEN = 1024,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N*W-1:0]    D,
    input  logic              D_VALID,
    output logic [N*W-1:0]    Q,
    output logic [DEST_W-1:0] DEST,
    output logic              DEST_VALID,
    output logic [N-1:0]      SOF,
    output logic [N-1:0]      EOF,
    output logic              FRAME,
    output logic [N-1:0]      HDR_VALID,
    output logic [N-1:0]      PLD_VALID,
    output logic              ERR,
    output logic [15:0]       FRAME_CNT
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PLD  = 2'd2;
    localparam logic [1:0] ST_SKIP = 2'd3;

    localparam logic [1:0] LC_ZERO = 2'd0;
    localparam logic [1:0] LC_OK   = 2'd1;
    localparam logic [1:0] LC_BIG  = 2'd2;

    localparam logic [31:0] MAX_LEN_C = 32'(MAX_LEN);
    localparam logic [31:0] TO_LAST_C = 32'(TIMEOUT - 1);
    localparam bit          TO_EN_C   = (TIMEOUT != 0);

    logic [1:0]        state_r;
    logic [LEN_W-1:0]  rem_r;
    logic              hdr_seen_r;
    logic [31:0]       idle_cnt_r;

    logic [1:0]        state_s;
    logic [LEN_W-1:0]  rem_s;
    logic              hdr_seen_s;
    logic [N-1:0]      sof_s;
    logic [N-1:0]      eof_s;
    logic [N-1:0]      hdr_s;
    logic [N-1:0]      pld_s;
    logic [DEST_W-1:0] dest_s;
    logic              dest_valid_s;
    logic              err_s;
    logic              frame_s;
    logic              open_s;
    logic              timeout_s;

    function automatic logic [1:0] len_class(input logic [LEN_W-1:0] len);
        logic [1:0] cls;
        if (len == {LEN_W{1'b0}}) begin
            cls = LC_ZERO;
        end else if (32'(len) <= MAX_LEN_C) begin
            cls = LC_OK;
        end else begin
            cls = LC_BIG;
        end
        return cls;
    endfunction

    // A frame is open while the registered walk sits in HDR or PLD.
    assign open_s    = (state_r == ST_HDR) || (state_r == ST_PLD);
    assign timeout_s = TO_EN_C && !D_VALID && open_s && (idle_cnt_r == TO_LAST_C);

    // Combinational lane walk: lane 0 first, state and REM carried lane to lane.
    always_comb begin : lane_walk
        logic [7:0]       tag_v;
        logic [LEN_W-1:0] len_v;
        logic             len_hit_v;
        tag_v        = 8'd0;
        len_v        = {LEN_W{1'b0}};
        len_hit_v    = 1'b0;
        state_s      = (state_r == ST_SKIP) ? ST_IDLE : state_r;
        rem_s        = rem_r;
        hdr_seen_s   = hdr_seen_r;
        sof_s        = {N{1'b0}};
        eof_s        = {N{1'b0}};
        hdr_s        = {N{1'b0}};
        pld_s        = {N{1'b0}};
        dest_s       = DEST;
        dest_valid_s = 1'b0;
        err_s        = 1'b0;
        frame_s      = (state_s == ST_HDR) || (state_s == ST_PLD);
        for (int i = 0; i < N; i++) begin
            tag_v     = D[i*W + W - 8 +: 8];
            len_v     = D[i*W +: LEN_W];
            len_hit_v = 1'b0;
            case (state_s)
                ST_IDLE: begin
                    case (tag_v)
                        8'h02: begin
                            sof_s[i]     = 1'b1;
                            hdr_s[i]     = 1'b1;
                            dest_s       = D[i*W +: DEST_W];
                            dest_valid_s = 1'b1;
                            hdr_seen_s   = 1'b0;
                            state_s      = ST_HDR;
                            frame_s      = 1'b1;
                        end
                        8'h01: begin
                            sof_s[i]   = 1'b1;
                            hdr_s[i]   = 1'b1;
                            hdr_seen_s = 1'b1;
                            state_s    = ST_HDR;
                            frame_s    = 1'b1;
                        end
                        8'h00: begin
                            sof_s[i]  = 1'b1;
                            frame_s   = 1'b1;
                            len_hit_v = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_HDR: begin
                    case (tag_v)
                        8'h02: begin
                            if (hdr_seen_s) begin
                                err_s   = 1'b1;
                                state_s = ST_SKIP;
                                frame_s = 1'b0;
                            end else begin
                                hdr_s[i] = 1'b1;
                            end
                        end
                        8'h01: begin
                            hdr_s[i]   = 1'b1;
                            hdr_seen_s = 1'b1;
                        end
                        8'h00: len_hit_v = 1'b1;
                        default: begin
                            err_s   = 1'b1;
                            state_s = ST_SKIP;
                            frame_s = 1'b0;
                        end
                    endcase
                end
                ST_PLD: begin
                    pld_s[i] = 1'b1;
                    if (rem_s == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        eof_s[i] = 1'b1;
                        rem_s    = {LEN_W{1'b0}};
                        state_s  = ST_SKIP;
                    end else begin
                        rem_s = rem_s - {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
            // Length word: classify L and open payload, close the frame, or abort.
            case ({len_hit_v, len_class(len_v)})
                3'b100: begin
                    hdr_s[i] = 1'b1;
                    eof_s[i] = 1'b1;
                    state_s  = ST_SKIP;
                end
                3'b101: begin
                    hdr_s[i] = 1'b1;
                    rem_s    = len_v;
                    state_s  = ST_PLD;
                end
                3'b110: begin
                    hdr_s[i] = 1'b1;
                    err_s    = 1'b1;
                    state_s  = ST_SKIP;
                    frame_s  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Walk state, REM and the mid-frame idle counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= ST_IDLE;
            rem_r      <= {LEN_W{1'b0}};
            hdr_seen_r <= 1'b0;
            idle_cnt_r <= 32'd0;
        end else if (D_VALID) begin
            state_r    <= state_s;
            rem_r      <= rem_s;
            hdr_seen_r <= hdr_seen_s;
            idle_cnt_r <= 32'd0;
        end else if (timeout_s) begin
            state_r    <= ST_IDLE;
            rem_r      <= {LEN_W{1'b0}};
            hdr_seen_r <= 1'b0;
            idle_cnt_r <= 32'd0;
        end else if (open_s) begin
            idle_cnt_r <= idle_cnt_r + 32'd1;
        end else begin
            idle_cnt_r <= 32'd0;
        end
    end

    // Registered data and per-lane flags; flags stay low in gap cycles.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q          <= {(N*W){1'b0}};
            DEST       <= {DEST_W{1'b0}};
            DEST_VALID <= 1'b0;
            SOF        <= {N{1'b0}};
            EOF        <= {N{1'b0}};
            HDR_VALID  <= {N{1'b0}};
            PLD_VALID  <= {N{1'b0}};
            ERR        <= 1'b0;
            FRAME      <= 1'b0;
        end else begin
            Q <= D;
            if (D_VALID) begin
                DEST       <= dest_s;
                DEST_VALID <= dest_valid_s;
                SOF        <= sof_s;
                EOF        <= eof_s;
                HDR_VALID  <= hdr_s;
                PLD_VALID  <= pld_s;
                ERR        <= err_s;
                FRAME      <= frame_s;
            end else begin
                DEST_VALID <= 1'b0;
                SOF        <= {N{1'b0}};
                EOF        <= {N{1'b0}};
                HDR_VALID  <= {N{1'b0}};
                PLD_VALID  <= {N{1'b0}};
                ERR        <= timeout_s;
                FRAME      <= open_s && !timeout_s;
            end
        end
    end

    // Completed-frame counter; one EOF per beat at most, wraps naturally.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            FRAME_CNT <= 16'd0;
        end else if (D_VALID && (|eof_s)) begin
            FRAME_CNT <= FRAME_CNT + 16'd1;
        end else begin
            FRAME_CNT <= FRAME_CNT;
        end
    end

endmodule

// File: tb/tb_routex_sink_multi.sv
// Directed bench for routex_sink_multi: an 8x64 instance and a 4x32 (MAX_LEN=16) instance.
module tb_routex_sink_multi;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [511:0] d8, q8;
    logic         v8, dv8, frame8, err8;
    logic [15:0]  dest8, cnt8;
    logic [7:0]   sof8, eof8, hdr8, pld8;

    logic [127:0] d4, q4;
    logic         v4, dv4, frame4, err4;
    logic [15:0]  dest4, cnt4;
    logic [3:0]   sof4, eof4, hdr4, pld4;

    int n_total = 0;
    int n_bad   = 0;
    logic err_seen;

    routex_sink_multi u8 (
        .CLK(clk), .RST_N(rst_n), .D(d8), .D_VALID(v8), .Q(q8), .DEST(dest8),
        .DEST_VALID(dv8), .SOF(sof8), .EOF(eof8), .FRAME(frame8), .HDR_VALID(hdr8),
        .PLD_VALID(pld8), .ERR(err8), .FRAME_CNT(cnt8)
    );

    routex_sink_multi #(.N(4), .W(32), .MAX_LEN(16)) u4 (
        .CLK(clk), .RST_N(rst_n), .D(d4), .D_VALID(v4), .Q(q4), .DEST(dest4),
        .DEST_VALID(dv4), .SOF(sof4), .EOF(eof4), .FRAME(frame4), .HDR_VALID(hdr4),
        .PLD_VALID(pld4), .ERR(err4), .FRAME_CNT(cnt4)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] w64(input logic [7:0] tag, input logic [55:0] body);
        return {tag, body};
    endfunction

    function automatic logic [31:0] w32(input logic [7:0] tag, input logic [23:0] body);
        return {tag, body};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lanes not set explicitly carry a tag the parser ignores in IDLE.
    task automatic fill8();
        for (int i = 0; i < 8; i++) d8[i*64 +: 64] = w64(8'hEE, 56'd0);
    endtask

    task automatic fill4();
        for (int i = 0; i < 4; i++) d4[i*32 +: 32] = w32(8'hEE, 24'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        d8 = '0; v8 = 1'b0; d4 = '0; v4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_q8", q8[63:0], 64'd0);
        check_eq("rst_cnt8", cnt8, 16'd0);
        check_eq("rst_frame8", frame8, 1'b0);
        check_eq("rst_cnt4", cnt4, 16'd0);
        rst_n = 1'b1;
        tick();

        // T1: 8 route/header, 8 header, 7 header + L=27, then 27 payload words.
        v8 = 1'b1;
        for (int i = 0; i < 8; i++) d8[i*64 +: 64] = w64((i < 3) ? 8'h02 : 8'h01, (i == 0) ? 56'd1 : 56'd5);
        tick();
        check_eq("t1_sof", sof8, 8'h01);
        check_eq("t1_dv", dv8, 1'b1);
        check_eq("t1_dest", dest8, 16'd1);
        check_eq("t1_hdr0", hdr8, 8'hFF);
        check_eq("t1_q_l3", q8[3*64 +: 64], w64(8'h01, 56'd5));
        for (int i = 0; i < 8; i++) d8[i*64 +: 64] = w64(8'h01, 56'd0);
        tick();
        check_eq("t1_hdr1", hdr8, 8'hFF);
        check_eq("t1_sof1", sof8, 8'h00);
        for (int i = 0; i < 8; i++) d8[i*64 +: 64] = (i < 7) ? w64(8'h01, 56'd0) : w64(8'h00, 56'd27);
        tick();
        check_eq("t1_hdr2", hdr8, 8'hFF);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) d8[i*64 +: 64] = w64(8'h02, 56'(b*8 + i + 1));
            tick();
            check_eq("t1_pld", pld8, 8'hFF);
            check_eq("t1_eof_mid", eof8, 8'h00);
        end
        for (int i = 0; i < 8; i++) d8[i*64 +: 64] = (i < 3) ? w64(8'h03, 56'(25 + i)) : w64(8'h02, 56'd9);
        tick();
        check_eq("t1_pld_last", pld8, 8'h07);
        check_eq("t1_eof", eof8, 8'h04);
        check_eq("t1_sof_drop", sof8, 8'h00);
        check_eq("t1_frame_eof", frame8, 1'b1);
        check_eq("t1_cnt", cnt8, 16'd1);
        check_eq("t1_dest_hold", dest8, 16'd1);

        // T2: back-to-back frame, L=10 spread over 8 + 2 payload words.
        for (int i = 0; i < 8; i++) d8[i*64 +: 64] = (i < 3) ? w64(8'h02, (i == 0) ? 56'hABC : 56'h111) :
                                                   (i < 7) ? w64(8'h01, 56'd0) : w64(8'h00, 56'd10);
        tick();
        check_eq("t2_sof", sof8, 8'h01);
        check_eq("t2_dest", dest8, 16'h0ABC);
        check_eq("t2_hdr", hdr8, 8'hFF);
        for (int i = 0; i < 8; i++) d8[i*64 +: 64] = w64(8'h00, 56'(i));
        tick();
        check_eq("t2_pld8", pld8, 8'hFF);
        for (int i = 0; i < 8; i++) d8[i*64 +: 64] = (i < 2) ? w64(8'h00, 56'd0) : w64(8'h02, 56'd3);
        tick();
        check_eq("t2_pld_last", pld8, 8'h03);
        check_eq("t2_eof", eof8, 8'h02);
        check_eq("t2_sof_drop", sof8, 8'h00);
        check_eq("t2_cnt", cnt8, 16'd2);
        v8 = 1'b0;
        tick();
        check_eq("t2_frame_idle", frame8, 1'b0);

        // T3: oversized length aborts the frame.
        v8 = 1'b1; fill8();
        d8[0 +: 64]  = w64(8'h02, 56'd4);
        d8[64 +: 64] = w64(8'h00, 56'd2000);
        d8[128 +: 64] = w64(8'h00, 56'd5);
        tick();
        check_eq("t3_err", err8, 1'b1);
        check_eq("t3_pld", pld8, 8'h00);
        check_eq("t3_eof", eof8, 8'h00);
        v8 = 1'b0;
        tick();
        check_eq("t3_frame", frame8, 1'b0);
        check_eq("t3_err_pulse", err8, 1'b0);
        check_eq("t3_cnt", cnt8, 16'd2);

        // T4a: 10-cycle gap inside payload, then resume.
        v8 = 1'b1;
        for (int i = 0; i < 8; i++) d8[i*64 +: 64] = (i == 0) ? w64(8'h02, 56'd6) :
                                                   (i == 1) ? w64(8'h00, 56'd12) : w64(8'h00, 56'(i));
        tick();
        check_eq("t4_pld0", pld8, 8'hFC);
        v8 = 1'b0; err_seen = 1'b0;
        repeat (10) begin tick(); err_seen |= err8; end
        check_eq("t4_gap10_err", err_seen, 1'b0);
        check_eq("t4_gap10_frame", frame8, 1'b1);
        v8 = 1'b1;
        for (int i = 0; i < 8; i++) d8[i*64 +: 64] = w64(8'h00, 56'(i));
        tick();
        check_eq("t4_pld1", pld8, 8'h3F);
        check_eq("t4_eof", eof8, 8'h20);
        check_eq("t4_cnt", cnt8, 16'd3);

        // T4b: 64-cycle gap times out exactly on the 64th idle cycle.
        for (int i = 0; i < 8; i++) d8[i*64 +: 64] = (i == 0) ? w64(8'h02, 56'd6) :
                                                   (i == 1) ? w64(8'h00, 56'd12) : w64(8'h00, 56'(i));
        tick();
        v8 = 1'b0; err_seen = 1'b0;
        repeat (63) begin tick(); err_seen |= err8; end
        check_eq("t4_gap63_err", err_seen, 1'b0);
        tick();
        check_eq("t4_to_err", err8, 1'b1);
        check_eq("t4_to_frame", frame8, 1'b0);
        v8 = 1'b1; fill8();
        d8[0 +: 64]   = w64(8'h02, 56'd7);
        d8[64 +: 64]  = w64(8'h00, 56'd1);
        d8[128 +: 64] = w64(8'h00, 56'd0);
        tick();
        check_eq("t4_new_sof", sof8, 8'h01);
        check_eq("t4_new_eof", eof8, 8'h04);
        check_eq("t4_new_dest", dest8, 16'd7);
        check_eq("t4_new_cnt", cnt8, 16'd4);

        // T5: lone L=0 length word, then reset mid-payload.
        fill8();
        d8[0 +: 64] = w64(8'h00, 56'd0);
        tick();
        check_eq("t5_sof", sof8, 8'h01);
        check_eq("t5_eof", eof8, 8'h01);
        check_eq("t5_hdr", hdr8, 8'h01);
        check_eq("t5_cnt", cnt8, 16'd5);
        for (int i = 0; i < 8; i++) d8[i*64 +: 64] = (i == 0) ? w64(8'h02, 56'd8) :
                                                   (i == 1) ? w64(8'h00, 56'd20) : w64(8'h00, 56'd1);
        tick();
        v8 = 1'b0;
        rst_n = 1'b0;
        #2;
        check_eq("t5_rst_q", q8[0 +: 64], 64'd0);
        check_eq("t5_rst_pld", pld8, 8'h00);
        check_eq("t5_rst_frame", frame8, 1'b0);
        check_eq("t5_rst_cnt", cnt8, 16'd0);
        check_eq("t5_rst_dest", dest8, 16'd0);
        tick();
        rst_n = 1'b1;
        v8 = 1'b1;
        for (int i = 0; i < 8; i++) d8[i*64 +: 64] = (i == 0) ? w64(8'h02, 56'd9) :
                                                   (i == 1) ? w64(8'h00, 56'd3) : w64(8'h02, 56'd1);
        tick();
        check_eq("t5_post_sof", sof8, 8'h01);
        check_eq("t5_post_pld", pld8, 8'h1C);
        check_eq("t5_post_eof", eof8, 8'h10);
        check_eq("t5_post_cnt", cnt8, 16'd1);
        v8 = 1'b0;

        // T6: 4x32 instance, resized T1, T3, then counter wrap.
        v4 = 1'b1;
        for (int i = 0; i < 4; i++) d4[i*32 +: 32] = w32((i < 2) ? 8'h02 : 8'h01, (i == 0) ? 24'h55 : 24'h3);
        tick();
        check_eq("t6_sof", sof4, 4'h1);
        check_eq("t6_dv", dv4, 1'b1);
        check_eq("t6_dest", dest4, 16'h0055);
        check_eq("t6_hdr0", hdr4, 4'hF);
        for (int i = 0; i < 4; i++) d4[i*32 +: 32] = (i < 3) ? w32(8'h01, 24'd0) : w32(8'h00, 24'd9);
        tick();
        check_eq("t6_hdr1", hdr4, 4'hF);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) d4[i*32 +: 32] = w32(8'h01, 24'(b*4 + i));
            tick();
            check_eq("t6_pld", pld4, 4'hF);
        end
        for (int i = 0; i < 4; i++) d4[i*32 +: 32] = (i == 0) ? w32(8'h00, 24'd9) : w32(8'h02, 24'd1);
        tick();
        check_eq("t6_pld_last", pld4, 4'h1);
        check_eq("t6_eof", eof4, 4'h1);
        check_eq("t6_sof_drop", sof4, 4'h0);
        check_eq("t6_cnt", cnt4, 16'd1);
        fill4();
        d4[0 +: 32]  = w32(8'h02, 24'd2);
        d4[32 +: 32] = w32(8'h00, 24'd17);
        tick();
        check_eq("t6_err", err4, 1'b1);
        check_eq("t6_err_pld", pld4, 4'h0);
        v4 = 1'b0;
        tick();
        check_eq("t6_frame", frame4, 1'b0);
        check_eq("t6_cnt_err", cnt4, 16'd1);
        v4 = 1'b1; fill4();
        d4[0 +: 32] = w32(8'h00, 24'd0);
        repeat (65534) tick();
        check_eq("t6_cnt_max", cnt4, 16'hFFFF);
        tick();
        check_eq("t6_cnt_wrap", cnt4, 16'h0000);
        v4 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
